// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared key index constants, column codes and event type for the
//             2x2 keypad front end.
//  Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

    localparam logic [1:0] KEY_0 = 2'd0;
    localparam logic [1:0] KEY_1 = 2'd1;
    localparam logic [1:0] KEY_2 = 2'd2;
    localparam logic [1:0] KEY_3 = 2'd3;

    localparam logic [1:0] COL_A = 2'b10;
    localparam logic [1:0] COL_B = 2'b01;

    typedef struct packed {
        logic [1:0] code;
        logic       press;
    } key_evt_t;

    // row_bit = 1 selects row[1], 0 selects row[0]
    function automatic logic [1:0] map_key(input logic row_bit, input logic [1:0] col_onehot);
        logic [1:0] k;
        if (row_bit) k = (col_onehot == COL_B) ? KEY_1 : KEY_0;
        else         k = (col_onehot == COL_B) ? KEY_3 : KEY_2;
        return k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_evt_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_evt_fifo
//  Purpose  : Show-ahead event FIFO; drops pushes when full (no pop) and
//             raises a sticky overflow flag.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_evt_fifo
    import keypad_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_push,
    input  key_evt_t i_data,
    input  logic     i_ready,
    output logic     o_valid,
    output key_evt_t o_head,
    output logic     o_overflow
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_FULL  = (c_PTR_W+1)'(DEPTH);

    key_evt_t           r_mem [DEPTH];
    key_evt_t           r_last;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_pop   = i_ready & ~w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept
    assign w_wr    = i_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_last     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr];
            end
            if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
            if (i_push && !w_wr)     r_overflow <= 1'b1;
        end
    end

    assign o_valid    = ~w_empty;
    assign o_head     = w_empty ? r_last : r_mem[r_rd_ptr];
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/keypad_scan_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan_debounce
//  Purpose  : 2x2 keypad column scanner with row synchronizer, per-key
//             debounce and a press/release event queue.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1200,
    parameter int DEBOUNCE_SCANS = 20,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] row,
    output logic [1:0] col,
    output logic [3:0] key_state,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_code,
    output logic       evt_press,
    output logic       evt_overflow
);

    localparam int                   c_DWELL_W    = $clog2(SCAN_DIV);
    localparam int                   c_CNT_W      = $clog2(DEBOUNCE_SCANS) + 1;
    localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(SCAN_DIV - 1);
    localparam logic [c_DWELL_W-1:0] c_DWELL_ONE  = c_DWELL_W'(1);
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST   = c_CNT_W'(DEBOUNCE_SCANS - 1);

    logic [c_DWELL_W-1:0] r_dwell;
    logic [1:0]           r_col;
    logic [1:0]           r_sync1;
    logic [1:0]           r_sync2;
    logic [1:0]           r_sample;
    logic [1:0]           r_sample_col;
    logic [3:0]           r_key_state;
    logic [c_CNT_W-1:0]   r_cnt [4];

    logic       w_upd_en;
    logic       w_upd_bit;
    logic [1:0] w_upd_key;
    logic       w_push;
    key_evt_t   w_push_evt;
    key_evt_t   w_head;

    // Scanner, synchronizer and end-of-dwell sample capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dwell      <= '0;
            r_col        <= COL_A;
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_sample     <= '0;
            r_sample_col <= COL_A;
        end else begin
            r_sync1 <= row;
            r_sync2 <= r_sync1;
            if (r_dwell == c_DWELL_LAST) begin
                r_dwell      <= '0;
                r_col        <= ~r_col;
                r_sample     <= r_sync2;
                r_sample_col <= r_col;
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    // One key per cycle keeps FIFO writes to at most one per cycle
    always_comb begin
        w_upd_en  = 1'b0;
        w_upd_bit = 1'b0;
        w_upd_key = KEY_0;
        if (r_dwell == '0) begin
            w_upd_en  = 1'b1;
            w_upd_bit = r_sample[1];
            w_upd_key = map_key(1'b1, r_sample_col);
        end else if (r_dwell == c_DWELL_ONE) begin
            w_upd_en  = 1'b1;
            w_upd_bit = r_sample[0];
            w_upd_key = map_key(1'b0, r_sample_col);
        end
    end

    assign w_push = w_upd_en && (w_upd_bit != r_key_state[w_upd_key])
                 && (r_cnt[w_upd_key] == c_CNT_LAST);

    always_comb begin
        w_push_evt       = '0;
        w_push_evt.code  = w_upd_key;
        w_push_evt.press = w_upd_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_state <= '0;
            for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
        end else if (w_upd_en) begin
            if (w_upd_bit == r_key_state[w_upd_key]) begin
                r_cnt[w_upd_key] <= '0;
            end else if (r_cnt[w_upd_key] == c_CNT_LAST) begin
                r_key_state[w_upd_key] <= w_upd_bit;
                r_cnt[w_upd_key]       <= '0;
            end else begin
                r_cnt[w_upd_key] <= r_cnt[w_upd_key] + 1'b1;
            end
        end
    end

    keypad_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_data     (w_push_evt),
        .i_ready    (evt_ready),
        .o_valid    (evt_valid),
        .o_head     (w_head),
        .o_overflow (evt_overflow)
    );

    assign col       = r_col;
    assign key_state = r_key_state;
    assign evt_code  = w_head.code;
    assign evt_press = w_head.press;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scan_debounce
//  Purpose  : Directed self-checking bench for keypad_scan_debounce with a
//             keypad model driving row from col and the pressed-key set.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scan_debounce;

    logic       clk;
    logic       rst;
    logic [1:0] row;
    logic [1:0] col;
    logic [3:0] key_state;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_code;
    logic       evt_press;
    logic       evt_overflow;

    logic [3:0] pressed;
    int         n_checks;
    int         n_errors;

    keypad_scan_debounce #(
        .SCAN_DIV       (8),
        .DEBOUNCE_SCANS (3),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .row          (row),
        .col          (col),
        .key_state    (key_state),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_press    (evt_press),
        .evt_overflow (evt_overflow)
    );

    // Keypad: row[1] carries keys 0/1, row[0] keys 2/3; col 10 selects keys 0/2
    assign row = (col == 2'b10) ? {pressed[0], pressed[2]} : {pressed[1], pressed[3]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the first negedge after col switches to target
    task automatic wait_col(input logic [1:0] target);
        logic [1:0] prev;
        logic       hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            prev = col;
            @(negedge clk);
            if (col == target && prev != target) hit = 1'b1;
        end
        check("wait_col", hit, 1);
    endtask

    task automatic pop_check(input string tag, input logic [1:0] code, input logic press);
        check({tag, "_valid"}, evt_valid, 1);
        check({tag, "_code"}, evt_code, code);
        check({tag, "_press"}, evt_press, press);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    initial begin
        int n_tog;
        int run;
        int bad_runs;
        int noisy;
        logic [1:0] prev;
        bit pat [8];

        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        evt_ready = 1'b0;
        pressed   = 4'b0000;
        pat       = '{1, 0, 1, 1, 0, 1, 0, 0};

        // Reset state
        step(3);
        check("rst_col", col, 2'b10);
        check("rst_key_state", key_state, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_code", evt_code, 0);
        check("rst_press", evt_press, 0);
        check("rst_overflow", evt_overflow, 0);
        rst = 1'b0;

        // 1: idle scanning, 8-cycle dwell per column
        n_tog = 0; run = 1; bad_runs = 0; noisy = 0; prev = col;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (col != prev) begin
                n_tog++;
                if (run != 8) bad_runs++;
                run = 1;
            end else begin
                run++;
            end
            if (col != 2'b10 && col != 2'b01) bad_runs++;
            if (evt_valid || key_state != 4'b0000) noisy++;
            prev = col;
        end
        check("t1_toggles", n_tog, 25);
        check("t1_dwell", bad_runs, 0);
        check("t1_quiet", noisy, 0);

        // 2: key 2 press and release
        wait_col(2'b10);
        pressed[2] = 1'b1;
        wait_col(2'b01);
        wait_col(2'b10);
        wait_col(2'b01);
        check("t2_ks_two_samples", key_state, 0);
        check("t2_valid_two_samples", evt_valid, 0);
        wait_col(2'b10);
        wait_col(2'b01);
        step(3);
        check("t2_ks_press", key_state, 4'b0100);
        pop_check("t2_press", 2'd2, 1'b1);
        check("t2_empty", evt_valid, 0);
        check("t2_hold_code", evt_code, 2);
        check("t2_hold_press", evt_press, 1);
        pressed[2] = 1'b0;
        repeat (3) begin
            wait_col(2'b10);
            wait_col(2'b01);
        end
        step(3);
        check("t2_ks_release", key_state, 0);
        pop_check("t2_release", 2'd2, 1'b0);

        // 3: key 1 chatter never reaches three consecutive samples
        for (int i = 0; i < 8; i++) begin
            wait_col(2'b01);
            pressed[1] = pat[i];
            check("t3_ks1", key_state[1], 0);
        end
        wait_col(2'b01);
        pressed[1] = 1'b0;
        wait_col(2'b10);
        step(3);
        check("t3_ks", key_state, 0);
        check("t3_valid", evt_valid, 0);

        // 4: keys 0 and 2 together, scan order 0 then 2
        wait_col(2'b10);
        pressed[0] = 1'b1;
        pressed[2] = 1'b1;
        repeat (3) begin
            wait_col(2'b01);
            if (col != 2'b01) check("t4_phase", col, 2'b01);
            wait_col(2'b10);
        end
        wait_col(2'b01);
        step(3);
        check("t4_ks_press", key_state, 4'b0101);
        pop_check("t4_first", 2'd0, 1'b1);
        pop_check("t4_second", 2'd2, 1'b1);
        check("t4_empty", evt_valid, 0);
        pressed = 4'b0000;
        repeat (3) begin
            wait_col(2'b10);
            wait_col(2'b01);
        end
        step(3);
        check("t4_ks_release", key_state, 0);
        pop_check("t4_rel0", 2'd0, 1'b0);
        pop_check("t4_rel2", 2'd2, 1'b0);

        // 5: five events with no consumer, fifth dropped
        wait_col(2'b10);
        pressed = 4'b1111;
        repeat (3) begin
            wait_col(2'b01);
            wait_col(2'b10);
        end
        step(3);
        check("t5_ks_all", key_state, 4'b1111);
        check("t5_no_overflow", evt_overflow, 0);
        pressed[0] = 1'b0;
        repeat (3) begin
            wait_col(2'b01);
            wait_col(2'b10);
        end
        step(3);
        check("t5_ks_rel0", key_state, 4'b1110);
        check("t5_overflow", evt_overflow, 1);
        pop_check("t5_pop0", 2'd0, 1'b1);
        pop_check("t5_pop1", 2'd2, 1'b1);
        pop_check("t5_pop2", 2'd1, 1'b1);
        pop_check("t5_pop3", 2'd3, 1'b1);
        evt_ready = 1'b1;
        step(3);
        check("t5_drained", evt_valid, 0);
        check("t5_hold_code", evt_code, 3);
        check("t5_sticky", evt_overflow, 1);
        evt_ready = 1'b0;

        // 6: reset mid-operation with events queued and key 3 mid-count
        pressed = 4'b0000;
        rst = 1'b1;
        step(1);
        check("t6_pre_overflow", evt_overflow, 0);
        check("t6_pre_ks", key_state, 0);
        rst = 1'b0;
        pressed = 4'b0101;
        wait_col(2'b01);
        wait_col(2'b10);
        wait_col(2'b01);
        wait_col(2'b10);
        pressed[3] = 1'b1;
        wait_col(2'b01);
        step(3);
        check("t6_queued_ks", key_state, 4'b0101);
        check("t6_queued_valid", evt_valid, 1);
        wait_col(2'b10);
        wait_col(2'b01);
        wait_col(2'b10);
        wait_col(2'b01);
        step(2);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", evt_valid, 0);
        check("t6_rst_col", col, 2'b10);
        check("t6_rst_ks", key_state, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_col(2'b01);
        wait_col(2'b10);
        step(3);
        check("t6_ks_one_sample", key_state, 0);
        check("t6_valid_one_sample", evt_valid, 0);
        wait_col(2'b01);
        wait_col(2'b10);
        wait_col(2'b01);
        step(3);
        check("t6_ks_again", key_state, 4'b0101);
        pop_check("t6_ev0", 2'd0, 1'b1);
        pop_check("t6_ev2", 2'd2, 1'b1);
        wait_col(2'b10);
        step(3);
        check("t6_ks_key3", key_state, 4'b1101);
        pop_check("t6_ev3", 2'd3, 1'b1);
        check("t6_empty", evt_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
`default_nettype wire
